upc_checkout_station: RTL

// Clocked, parametrised checkout station for UPC-coded items. Latches a scanned code and secret mark.

---
 rtl/upc_pkg.sv | 97 +++++++++
 rtl/upc_scroll_display.sv | 93 +++++++++
 rtl/upc_checkout_station.sv | 105 ++++++++++
 3 files changed

// File: rtl/upc_pkg.sv
// Shared definitions for the UPC checkout station: 7-segment glyphs,
// the item record and the item table lookup.
package upc_pkg;

   // Characters per item name slot. Kept here because item_t depends on it.
   localparam int NAME_LEN = 8;
   // Wide enough to hold a name length of 0..NAME_LEN.
   localparam int LEN_W    = $clog2(NAME_LEN + 1);

   typedef logic [6:0] seg_t;

   // Active-low glyphs, bit0 = segment a ... bit6 = segment g.
   localparam seg_t SEG_S     = 7'h12;
   localparam seg_t SEG_H     = 7'h09;
   localparam seg_t SEG_O     = 7'h40;
   localparam seg_t SEG_E     = 7'h06;
   localparam seg_t SEG_P     = 7'h0C;
   localparam seg_t SEG_N     = 7'h2B;   // lower-case n
   localparam seg_t SEG_C     = 7'h46;
   localparam seg_t SEG_Y     = 7'h11;   // lower-case y
   localparam seg_t SEG_L     = 7'h47;
   localparam seg_t SEG_U     = 7'h63;   // lower-case u
   localparam seg_t SEG_I     = 7'h79;
   localparam seg_t SEG_T     = 7'h07;   // lower-case t
   localparam seg_t SEG_A     = 7'h08;
   localparam seg_t SEG_R     = 7'h2F;   // lower-case r shape
   localparam seg_t SEG_D     = 7'h21;   // lower-case d shape
   localparam seg_t SEG_DASH  = 7'h3F;
   localparam seg_t SEG_BLANK = 7'h7F;

   typedef enum logic {
      ST_IDLE,
      ST_SHOW
   } state_t;

   // name[0] is the leftmost character; unused slots hold SEG_BLANK.
   typedef struct packed {
      seg_t [NAME_LEN-1:0] name;
      logic [LEN_W-1:0]    len;
      logic                discounted;
      logic                expensive;
   } item_t;

   // Item table; codes outside it map to the "----" unknown entry.
   function automatic item_t lookup_item(input logic [31:0] code);
      item_t it;
      it.name       = {NAME_LEN{SEG_BLANK}};
      it.len        = LEN_W'(4);
      it.discounted = 1'b0;
      it.expensive  = 1'b0;
      case (code)
         32'd0: begin
            it.name[0] = SEG_S; it.name[1] = SEG_H;
            it.name[2] = SEG_O; it.name[3] = SEG_E;
            it.expensive = 1'b1;
         end
         32'd1: begin
            it.name[0] = SEG_P; it.name[1] = SEG_E; it.name[2] = SEG_N;
            it.len = LEN_W'(3);
         end
         32'd3: begin
            it.name[0] = SEG_C; it.name[1] = SEG_Y; it.name[2] = SEG_C;
            it.name[3] = SEG_L; it.name[4] = SEG_E;
            it.len = LEN_W'(5);
            it.discounted = 1'b1;
         end
         32'd4: begin
            it.name[0] = SEG_S; it.name[1] = SEG_U;
            it.name[2] = SEG_I; it.name[3] = SEG_T;
            it.expensive = 1'b1;
         end
         32'd5: begin
            it.name[0] = SEG_C; it.name[1] = SEG_O;
            it.name[2] = SEG_A; it.name[3] = SEG_T;
            it.discounted = 1'b1;
            it.expensive  = 1'b1;
         end
         32'd6: begin
            it.name[0] = SEG_R; it.name[1] = SEG_E; it.name[2] = SEG_C;
            it.name[3] = SEG_O; it.name[4] = SEG_R; it.name[5] = SEG_D;
            it.len = LEN_W'(6);
            it.discounted = 1'b1;
         end
         default: begin
            it.name[0] = SEG_DASH; it.name[1] = SEG_DASH;
            it.name[2] = SEG_DASH; it.name[3] = SEG_DASH;
         end
      endcase
      return it;
   endfunction

   function automatic logic item_known(input logic [31:0] code);
      return (code == 32'd0) || (code == 32'd1) || (code == 32'd3) ||
             (code == 32'd4) || (code == 32'd5) || (code == 32'd6);
   endfunction

endpackage

// File: rtl/upc_scroll_display.sv
// Holds the current item name and drives the 7-segment bank. Names that fit
// are shown left-aligned; longer names scroll through {name, blank} one
// character every SCROLL_DIV cycles.
module upc_scroll_display
   import upc_pkg::*;
#(
   parameter int N_DIGITS   = 6,
   parameter int SCROLL_DIV = 25_000_000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [7*NAME_LEN-1:0]   name,
   input  logic [LEN_W-1:0]        len,
   output logic [7*N_DIGITS-1:0]   hex
);

   localparam int DIV_W = $clog2(SCROLL_DIV);
   localparam int IDX_W = LEN_W + 1;   // holds pos + slot before the wrap
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

   logic [7*NAME_LEN-1:0] r_name;
   logic [LEN_W-1:0]      r_len;
   logic [LEN_W-1:0]      r_pos;
   logic [DIV_W-1:0]      r_div;
   logic                  w_scroll;
   logic [IDX_W-1:0]      w_len1;

   assign w_scroll = (32'(r_len) > N_DIGITS);
   assign w_len1   = {1'b0, r_len} + 1'b1;

   // Name latch, step divider and wrap-at-(len+1) scroll position.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_name <= {NAME_LEN{SEG_BLANK}};
         r_len  <= '0;
         r_pos  <= '0;
         r_div  <= '0;
      end else if (load) begin
         r_name <= name;
         r_len  <= len;
         r_pos  <= '0;
         r_div  <= '0;
      end else if (w_scroll) begin
         if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_pos <= (r_pos == r_len) ? '0 : r_pos + 1'b1;
         end else begin
            r_div <= r_div + 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         // Window slot shown on this digit; slot 0 is the leftmost digit.
         localparam int K = N_DIGITS - 1 - gi;
         logic [IDX_W-1:0] w_sum;
         logic [IDX_W-1:0] w_idx;
         logic             w_show;
         seg_t             w_char;

         // Pick the name character (or blank) for this window slot.
         always_comb begin
            w_sum  = {1'b0, r_pos} + IDX_W'(K);
            w_idx  = w_sum;
            w_show = 1'b0;
            w_char = SEG_BLANK;
            if (w_scroll) begin
               // pos <= len and slot < len, so one subtraction wraps.
               if (w_sum >= w_len1) begin
                  w_idx = w_sum - w_len1;
               end
               w_show = (w_idx < {1'b0, r_len});
            end else begin
               w_idx  = IDX_W'(K);
               w_show = (K < 32'(r_len));
            end
            if (w_show) begin
               for (int c = 0; c < NAME_LEN; c++) begin
                  if (w_idx == IDX_W'(c)) begin
                     w_char = r_name[7*c +: 7];
                  end
               end
            end
         end

         assign hex[7*gi +: 7] = w_char;
      end
   endgenerate

endmodule

// File: rtl/upc_checkout_station.sv
// Checkout station top: latches each scan, flags discounted/unknown items,
// keeps saturating tallies and a sticky stolen alarm, and shows the item
// name through upc_scroll_display.
module upc_checkout_station
   import upc_pkg::*;
#(
   parameter int UPC_W      = 3,
   parameter int N_DIGITS   = 6,
   parameter int SCROLL_DIV = 25_000_000,
   parameter int CNT_W      = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   scan,
   input  logic [UPC_W-1:0]       upc,
   input  logic                   mark,
   input  logic                   clear_alarm,
   output logic [7*N_DIGITS-1:0]  hex,
   output logic                   discounted,
   output logic                   stolen_alarm,
   output logic                   valid_item,
   output logic [CNT_W-1:0]       scan_count,
   output logic [CNT_W-1:0]       stolen_count
);

   state_t           r_state;
   state_t           w_state_next;
   item_t            w_item;
   logic             w_known;
   logic             w_stolen;
   logic             r_discounted;
   logic             r_alarm;
   logic             r_valid;
   logic [CNT_W-1:0] r_scan_count;
   logic [CNT_W-1:0] r_stolen_count;

   assign w_item   = lookup_item(32'(upc));
   assign w_known  = item_known(32'(upc));
   assign w_stolen = w_item.expensive & ~mark;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: the first scan leaves IDLE; SHOW only reloads.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (scan) w_state_next = ST_SHOW;
         ST_SHOW: w_state_next = ST_SHOW;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Item flags, saturating tallies and the sticky alarm (set beats clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_discounted   <= 1'b0;
         r_valid        <= 1'b0;
         r_alarm        <= 1'b0;
         r_scan_count   <= '0;
         r_stolen_count <= '0;
      end else begin
         if (scan) begin
            r_discounted <= w_item.discounted;
            r_valid      <= w_known;
            if (r_scan_count != '1) begin
               r_scan_count <= r_scan_count + 1'b1;
            end
            if (w_stolen && (r_stolen_count != '1)) begin
               r_stolen_count <= r_stolen_count + 1'b1;
            end
         end
         if (scan && w_stolen) begin
            r_alarm <= 1'b1;
         end else if (clear_alarm) begin
            r_alarm <= 1'b0;
         end
      end
   end

   upc_scroll_display #(
      .N_DIGITS   (N_DIGITS),
      .SCROLL_DIV (SCROLL_DIV)
   ) u_display (
      .clk   (clk),
      .reset (reset),
      .load  (scan),
      .name  (w_item.name),
      .len   (w_item.len),
      .hex   (hex)
   );

   assign discounted   = r_discounted;
   assign stolen_alarm = r_alarm;
   assign valid_item   = r_valid;
   assign scan_count   = r_scan_count;
   assign stolen_count = r_stolen_count;

endmodule
